// File: rtl/vote_link_pkg.sv
// Shared types for the voting-unit link peer: FSM state encoding and the link data width.
package vote_link_pkg;

    localparam int VL_DATA_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_REQ,
        ST_TX_REL,
        ST_RX_REQ,
        ST_RX_REL
    } vote_link_state_t;

endpackage

// File: rtl/vote_link_fifo.sv
// Receive FIFO for the link peer. A slot is reserved when a receive is armed, so a push never overflows.
module vote_link_fifo
    import vote_link_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 reserve,
    input  logic                 cancel,
    input  logic                 push,
    input  logic [VL_DATA_W-1:0] push_data,
    input  logic                 pop,
    output logic [VL_DATA_W-1:0] pop_data,
    output logic                 empty,
    output logic                 full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [VL_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 rsv;

    // A push consumes the outstanding reservation; a cancel drops it without storing data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rsv    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (push || cancel) rsv <= 1'b0;
            else if (reserve)   rsv <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count + CW'(rsv)) >= CW'(DEPTH);

endmodule

// File: rtl/vote_link_peer.sv
// Far-end partner for the voting unit's four-phase rts/cts and rtr/ctr link.
// Define VOTE_LINK_TIMEOUT_EN to enable the wait-state timeout, err and err_clr.
module vote_link_peer
    import vote_link_pkg::*;
#(
    parameter int RX_DEPTH = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cts,
    input  logic                 ctr,
    input  logic [VL_DATA_W-1:0] v_out,
    output logic                 rts,
    output logic                 rtr,
    output logic [VL_DATA_W-1:0] v_in,
    input  logic                 tx_valid,
    input  logic [VL_DATA_W-1:0] tx_data,
    output logic                 tx_ready,
    input  logic                 rx_en,
    output logic                 rx_valid,
    output logic [VL_DATA_W-1:0] rx_data,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 err,
    input  logic                 err_clr
);

    vote_link_state_t state, state_next;

    logic                 cts_meta, cts_s, ctr_meta, ctr_s;
    logic [VL_DATA_W-1:0] tx_hold;
    logic                 tx_full;
    logic                 last_rx;
    logic                 tx_grant, rx_grant, tx_done, rx_push, rx_abort;
    logic                 timeout_hit;
    logic                 fifo_empty, fifo_full;

    assign tx_ready = !tx_full;
    assign rx_valid = !fifo_empty;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Arbitration alternates via last_rx when both directions want the link; a timeout aborts any wait.
    always_comb begin
        state_next = state;
        tx_grant   = 1'b0;
        rx_grant   = 1'b0;
        tx_done    = 1'b0;
        rx_push    = 1'b0;
        rx_abort   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_full && (!(rx_en && !fifo_full) || last_rx)) begin
                    tx_grant   = 1'b1;
                    state_next = ST_TX_REQ;
                end else if (rx_en && !fifo_full) begin
                    rx_grant   = 1'b1;
                    state_next = ST_RX_REQ;
                end
            end
            ST_TX_REQ: begin
                if (timeout_hit) begin
                    state_next = ST_IDLE;
                end else if (cts_s) begin
                    tx_done    = 1'b1;
                    state_next = ST_TX_REL;
                end
            end
            ST_TX_REL: begin
                if (timeout_hit || !cts_s) state_next = ST_IDLE;
            end
            ST_RX_REQ: begin
                if (timeout_hit) begin
                    rx_abort   = 1'b1;
                    state_next = ST_IDLE;
                end else if (ctr_s) begin
                    rx_push    = 1'b1;
                    state_next = ST_RX_REL;
                end
            end
            ST_RX_REL: begin
                if (timeout_hit || !ctr_s) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cts_meta <= 1'b0;
            cts_s    <= 1'b0;
            ctr_meta <= 1'b0;
            ctr_s    <= 1'b0;
            rts      <= 1'b0;
            rtr      <= 1'b0;
            v_in     <= '0;
            tx_hold  <= '0;
            tx_full  <= 1'b0;
            last_rx  <= 1'b0;
        end else begin
            cts_meta <= cts;
            cts_s    <= cts_meta;
            ctr_meta <= ctr;
            ctr_s    <= ctr_meta;
            if (tx_grant) begin
                rts  <= 1'b1;
                v_in <= tx_hold;
            end else if (tx_done || timeout_hit) begin
                rts <= 1'b0;
            end
            if (rx_grant)                  rtr <= 1'b1;
            else if (rx_push || timeout_hit) rtr <= 1'b0;
            // An aborted send leaves tx_full set so the same nibble is offered again.
            if (tx_done) begin
                tx_full <= 1'b0;
            end else if (tx_valid && !tx_full) begin
                tx_full <= 1'b1;
                tx_hold <= tx_data;
            end
            if (tx_grant)      last_rx <= 1'b0;
            else if (rx_grant) last_rx <= 1'b1;
        end
    end

`ifdef VOTE_LINK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT);

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state_next != state)  tmo_cnt <= '0;
            else if (state != ST_IDLE) tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (timeout_hit)  err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

    assign timeout_hit = (state != ST_IDLE) && (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
    logic [1:0] unused_cfg;
    assign unused_cfg  = {err_clr, (TIMEOUT > 0)};
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    vote_link_fifo #(
        .DEPTH(RX_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .reserve  (rx_grant),
        .cancel   (rx_abort),
        .push     (rx_push),
        .push_data(v_out),
        .pop      (rx_valid && rx_ready),
        .pop_data (rx_data),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: doc/vote_link_peer.md
# vote_link_peer

Synthesizable far-end partner for the voting unit's request/clear handshake link. It drives `rts`, `rtr` and `v_in` and consumes `cts`, `ctr` and `v_out`, completing both four-phase channels in place of the external stimulus source. Nibbles to send arrive from a local valid/ready port; nibbles received from the link are buffered in a small FIFO. It sits at the link pins of the voting unit and replaces the stimulus-replay harness in closed-loop system runs.

## Interface
Parameters:
- `RX_DEPTH`, 4: receive FIFO entries; power of two, ≥2.
- `TIMEOUT`, 64: maximum cycles spent in one wait state before abort; ≥4.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cts` in 1: clear-to-send from the far unit; asynchronous.
- `ctr` in 1: clear-to-receive from the far unit; asynchronous.
- `v_out` in 4: data from the far unit; stable while `ctr` is high.
- `rts` out 1: request-to-send.
- `rtr` out 1: ready-to-receive.
- `v_in` out 4: data to the far unit.
- `tx_valid` in 1, `tx_data` in 4, `tx_ready` out 1: local send port.
- `rx_en` in 1: permits arming receive transfers.
- `rx_valid` out 1, `rx_data` out 4, `rx_ready` in 1: local receive port (FIFO head).
- `busy` out 1: FSM not in IDLE.
- `err` out 1: sticky timeout flag. `err_clr` in 1 clears it.

## Operation
- `cts` and `ctr` pass through 2-flop synchronizers; the FSM uses only the synchronized values (`cts_s`, `ctr_s`).
- Send holding register: one entry. `tx_ready = !tx_full`. The register loads on `tx_valid && tx_ready`.
- FSM states: IDLE, TX_REQ, TX_REL, RX_REQ, RX_REL.
  - IDLE: the TX candidate is `tx_full`. The RX candidate is `rx_en && fifo_free >= 1`. If both are candidates, a round-robin bit `last_rx` selects: TX if `last_rx=1`, RX otherwise. The bit updates on each grant.
  - TX grant: `v_in` ← hold register, `rts`←1, go to TX_REQ.
  - TX_REQ: on `cts_s=1`: `rts`←0, `tx_full`←0, go to TX_REL.
  - TX_REL: on `cts_s=0` → IDLE. `v_in` holds its value until IDLE is re-entered, then holds the last value.
  - RX grant: `rtr`←1, go to RX_REQ.
  - RX_REQ: on `ctr_s=1`: push `v_out` into the FIFO, `rtr`←0, go to RX_REL.
  - RX_REL: on `ctr_s=0` → IDLE.
- The FIFO reserves the entry at RX grant. A push can never overflow. `rx_valid = !empty`. A pop occurs on `rx_valid && rx_ready`. Simultaneous push and pop are permitted, including when full.
- Timeout: a counter clears on every state entry and increments in REQ/REL states. At count `TIMEOUT-1`:
  - `rts`/`rtr` ← 0, `err` ← 1, state ← IDLE.
  - A TX abort keeps `tx_full` set, so the nibble is retried.
  - An RX abort releases the reservation without a push.
- `err_clr` clears `err`. If it coincides with a new timeout, the set wins.
- Reset values: `rts`=0, `rtr`=0, `v_in`=0, `rx_valid`=0, `busy`=0, `err`=0, `tx_ready`=1, FIFO empty, `last_rx`=0, state IDLE. Reset mid-transfer drops everything, with no completion.

## Timing
- Acceptance at edge N: `rts` is high after edge N+1 at the earliest.
- Far-side `cts` rise is visible to the FSM 2 edges later. `rts` falls on the following edge, so the minimum `cts`-rise → `rts`-fall is 3 cycles.
- Minimum full TX transfer is 1+3+3 cycles. RX is the same, with `ctr`/`rtr`.
- An RX push is visible on `rx_valid` the cycle after the `rtr` fall edge.
- `tx_ready` rises the cycle after the `rts` fall. A new word is accepted on that cycle and does not restart the current transfer.

## Configuration
- `VOTE_LINK_TIMEOUT_EN` defined: the timeout counter, `err` and `err_clr` are active.
- `VOTE_LINK_TIMEOUT_EN` undefined: no counter, wait states wait indefinitely, `err` is tied 0 and `err_clr` is ignored.

## Structure
- Shared package `vote_link_pkg`: state enum `vote_link_state_t`, `VL_DATA_W=4`.
- Sub-module `vote_link_fifo` (`RX_DEPTH`, 4-bit data, reservation count, full/empty). Synchronizers are inline.

## Test plan
- Single send: `tx_data=4'hA`; the responder raises `cts` 2 cycles after `rts`, then drops `cts` after `rts` falls → `v_in=4'hA` stable throughout, `tx_ready` returns to 1, `err=0`.
- Single receive: `rx_en=1`; the responder drives `v_out=4'h5` and raises `ctr` → `rx_valid=1`, `rx_data=4'h5`, `rtr` low before `ctr` drops.
- Contention: TX pending plus `rx_en` from reset → RX first, then TX, then RX, strictly alternating over 6 transfers.
- FIFO full: `rx_ready=0`, 4 receives → the FSM stops arming `rtr`. One pop → exactly one more transfer.
- Timeout (EN defined, `TIMEOUT=8`): `cts` held 0 → `rts` drops 8 cycles after TX_REQ entry, `err=1`, retry follows. `err_clr` → `err=0`.
- Reset asserted in TX_REL → all outputs at reset values immediately; `tx_ready=1` after release.
